trigger_detector: RTL and testbench

//   Level/edge trigger generator sitting directly upstream of the acquisition controller.

---
 rtl/trigger_detector.sv | 116 +++++++++++
 tb/tb_trigger_detector.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_detector.sv
// Level/edge trigger generator with hysteresis priming and holdoff.
// Searches the strobed ADC stream only while armed by the acquisition controller.
module trigger_detector #(
   parameter int W    = 8,
   parameter int HO_W = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [W-1:0]    adc_data,
   input  logic            sample_en,
   input  logic            arm,
   input  logic [W-1:0]    level,
   input  logic [W-1:0]    hysteresis,
   input  logic            slope,
   input  logic [HO_W-1:0] holdoff,
   output logic            trigger_req,
   output logic            primed,
   output logic            holdoff_active
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_PRIME = 2'd1;
   localparam logic [1:0] S_READY = 2'd2;
   localparam logic [1:0] S_HOLD  = 2'd3;

   logic [1:0]      state_q, state_d;
   logic            trig_q, trig_d;
   logic [HO_W-1:0] cnt_q, cnt_d;
   logic [W-1:0]    lvl_q, lvl_d;
   logic [W-1:0]    hys_q, hys_d;
   logic            slope_q, slope_d;
   logic [HO_W-1:0] ho_q, ho_d;

   logic [W:0]      lo_ext, hi_ext;
   logic [W-1:0]    lo_thr, hi_thr;
   logic            prime_hit, trig_hit;

   // Extra bit exposes borrow/carry so the band clamps at the code range ends
   assign lo_ext = {1'b0, lvl_q} - {1'b0, hys_q};
   assign hi_ext = {1'b0, lvl_q} + {1'b0, hys_q};
   assign lo_thr = lo_ext[W] ? '0 : lo_ext[W-1:0];
   assign hi_thr = hi_ext[W] ? '1 : hi_ext[W-1:0];

   assign prime_hit = slope_q ? (adc_data > hi_thr) : (adc_data < lo_thr);
   assign trig_hit  = slope_q ? (adc_data <= lvl_q) : (adc_data >= lvl_q);

   always_comb begin
      state_d = state_q;
      trig_d  = 1'b0;
      cnt_d   = cnt_q;
      lvl_d   = lvl_q;
      hys_d   = hys_q;
      slope_d = slope_q;
      ho_d    = ho_q;
      if (state_q != S_IDLE && !arm) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (arm) begin
                  lvl_d   = level;
                  hys_d   = hysteresis;
                  slope_d = slope;
                  ho_d    = holdoff;
                  state_d = S_PRIME;
               end
            end
            S_PRIME: begin
               if (sample_en && prime_hit) state_d = S_READY;
            end
            S_READY: begin
               if (sample_en && trig_hit) begin
                  trig_d  = 1'b1;
                  cnt_d   = ho_q;
                  state_d = (ho_q != '0) ? S_HOLD : S_PRIME;
               end
            end
            S_HOLD: begin
               if (sample_en) begin
                  cnt_d = cnt_q - HO_W'(1);
                  if (cnt_q <= HO_W'(1)) begin
                     cnt_d   = '0;
                     state_d = S_PRIME;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         trig_q  <= 1'b0;
         cnt_q   <= '0;
         lvl_q   <= '0;
         hys_q   <= '0;
         slope_q <= 1'b0;
         ho_q    <= '0;
      end else begin
         state_q <= state_d;
         trig_q  <= trig_d;
         cnt_q   <= cnt_d;
         lvl_q   <= lvl_d;
         hys_q   <= hys_d;
         slope_q <= slope_d;
         ho_q    <= ho_d;
      end
   end

   assign trigger_req    = trig_q;
   assign primed         = (state_q == S_READY);
   assign holdoff_active = (state_q == S_HOLD);

endmodule

// File: tb/tb_trigger_detector.sv
// Randomised and directed checks of trigger_detector against a
// behavioural model built from the trigger rules.
module tb_trigger_detector;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  adc_data;
   logic        sample_en;
   logic        arm;
   logic [7:0]  level;
   logic [7:0]  hysteresis;
   logic        slope;
   logic [15:0] holdoff;
   logic        trigger_req, primed, holdoff_active;

   int tests = 0;
   int fails = 0;

   // model: mode 0 idle, 1 searching below/above band, 2 primed, 3 holdoff
   int m_mode, m_cnt, m_lvl, m_hys, m_slope, m_ho;
   bit m_trig;
   int ntrig, nprimed, nhold, strobe_idx;
   int trig_at[$];

   trigger_detector dut (
      .clk(clk), .rst_n(rst_n), .adc_data(adc_data),
      .sample_en(sample_en), .arm(arm), .level(level),
      .hysteresis(hysteresis), .slope(slope), .holdoff(holdoff),
      .trigger_req(trigger_req), .primed(primed),
      .holdoff_active(holdoff_active)
   );

   always #5 clk = ~clk;

   task automatic model_edge();
      int d, lo, hi;
      d = int'(adc_data);
      lo = m_lvl - m_hys;
      if (lo < 0) lo = 0;
      hi = m_lvl + m_hys;
      if (hi > 255) hi = 255;
      if (!rst_n) begin
         m_mode = 0; m_trig = 0; m_cnt = 0;
         m_lvl = 0; m_hys = 0; m_slope = 0; m_ho = 0;
         return;
      end
      m_trig = 0;
      if (m_mode != 0 && !arm) begin
         m_mode = 0;
         return;
      end
      if (m_mode == 0) begin
         if (arm) begin
            m_lvl = int'(level); m_hys = int'(hysteresis);
            m_slope = int'(slope); m_ho = int'(holdoff);
            m_mode = 1;
         end
      end else if (!sample_en) begin
      end else if (m_mode == 1) begin
         if (m_slope == 0 ? d < lo : d > hi) m_mode = 2;
      end else if (m_mode == 2) begin
         if (m_slope == 0 ? d >= m_lvl : d <= m_lvl) begin
            m_trig = 1;
            m_cnt = m_ho;
            m_mode = (m_ho > 0) ? 3 : 1;
         end
      end else begin
         m_cnt = m_cnt - 1;
         if (m_cnt <= 0) begin
            m_cnt = 0;
            m_mode = 1;
         end
      end
   endtask

   task automatic step(input bit r, input bit a, input bit e, input int d);
      rst_n = r; arm = a; sample_en = e; adc_data = 8'(d);
      @(posedge clk);
      model_edge();
      if (e) strobe_idx++;
      #1;
      tests++;
      if (trigger_req !== m_trig) begin
         fails++;
         $display("FAIL trigger_req t=%0t got %b exp %b", $time, trigger_req, m_trig);
      end
      tests++;
      if (primed !== (m_mode == 2)) begin
         fails++;
         $display("FAIL primed t=%0t got %b exp %b", $time, primed, m_mode == 2);
      end
      tests++;
      if (holdoff_active !== (m_mode == 3)) begin
         fails++;
         $display("FAIL holdoff_active t=%0t got %b exp %b", $time, holdoff_active, m_mode == 3);
      end
      if (trigger_req === 1'b1) begin
         ntrig++;
         trig_at.push_back(strobe_idx);
      end
      if (primed === 1'b1) nprimed++;
      if (holdoff_active === 1'b1) nhold++;
   endtask

   task automatic cfg(input int l, input int h, input bit s, input int ho);
      level = 8'(l); hysteresis = 8'(h); slope = s; holdoff = 16'(ho);
   endtask

   task automatic restart();
      step(0, 0, 0, 0);
      step(1, 1, 0, 0);
      ntrig = 0; nprimed = 0; nhold = 0; strobe_idx = 0;
      trig_at.delete();
   endtask

   task automatic test_reset();
      cfg(0, 0, 0, 0);
      step(0, 0, 0, 0);
      step(0, 1, 1, 200);
      tests++;
      if ({trigger_req, primed, holdoff_active} !== 3'b000) begin
         fails++;
         $display("FAIL reset_outputs got %b exp 000", {trigger_req, primed, holdoff_active});
      end
   endtask

   task automatic test_rising();
      cfg(128, 16, 0, 0);
      restart();
      step(1, 1, 1, 100);
      tests++;
      if (primed !== 1'b1) begin
         fails++;
         $display("FAIL rising_primed got %b exp 1", primed);
      end
      step(1, 1, 1, 120);
      step(1, 1, 1, 130);
      tests++;
      if (trigger_req !== 1'b1) begin
         fails++;
         $display("FAIL rising_pulse got %b exp 1", trigger_req);
      end
      step(1, 1, 0, 0);
      step(1, 1, 0, 0);
      tests++;
      if (ntrig !== 1) begin
         fails++;
         $display("FAIL rising_count got %0d exp 1", ntrig);
      end
   endtask

   task automatic test_hyst_reject();
      cfg(128, 16, 0, 0);
      restart();
      foreach (trig_at[i]) begin end
      step(1, 1, 1, 130);
      step(1, 1, 1, 115);
      step(1, 1, 1, 129);
      step(1, 1, 0, 0);
      tests++;
      if (ntrig !== 0 || nprimed !== 0) begin
         fails++;
         $display("FAIL hyst_reject trig=%0d primed=%0d exp 0/0", ntrig, nprimed);
      end
   endtask

   task automatic test_falling();
      cfg(50, 10, 1, 0);
      restart();
      step(1, 1, 1, 70);
      step(1, 1, 1, 55);
      step(1, 1, 1, 50);
      step(1, 1, 0, 0);
      tests++;
      if (ntrig !== 1 || nprimed !== 2) begin
         fails++;
         $display("FAIL falling trig=%0d primed=%0d exp 1/2", ntrig, nprimed);
      end
   endtask

   task automatic test_holdoff();
      cfg(128, 16, 0, 3);
      restart();
      for (int i = 0; i < 24; i++) step(1, 1, 1, (i % 2) ? 255 : 0);
      tests++;
      if (trig_at.size() < 3) begin
         fails++;
         $display("FAIL holdoff_trigs got %0d exp >=3", trig_at.size());
      end
      for (int i = 1; i < trig_at.size(); i++) begin
         tests++;
         if (trig_at[i] - trig_at[i-1] < 5) begin
            fails++;
            $display("FAIL holdoff_gap got %0d exp >=5", trig_at[i] - trig_at[i-1]);
         end
      end
      tests++;
      if (nhold < 3 * (trig_at.size() - 1) || nhold > 3 * trig_at.size()) begin
         fails++;
         $display("FAIL holdoff_len got %0d for %0d pulses", nhold, trig_at.size());
      end
   endtask

   task automatic test_disarm();
      cfg(128, 16, 0, 2);
      restart();
      step(1, 1, 1, 10);
      step(1, 0, 1, 200);
      step(1, 0, 0, 0);
      tests++;
      if (ntrig !== 0 || primed !== 1'b0) begin
         fails++;
         $display("FAIL disarm trig=%0d primed=%b exp 0/0", ntrig, primed);
      end
      step(1, 1, 0, 0);
      step(1, 1, 1, 10);
      step(1, 1, 1, 200);
      tests++;
      if (holdoff_active !== 1'b1) begin
         fails++;
         $display("FAIL reenter_holdoff got %b exp 1", holdoff_active);
      end
      step(0, 1, 1, 10);
      tests++;
      if ({trigger_req, primed, holdoff_active} !== 3'b000) begin
         fails++;
         $display("FAIL mid_reset got %b exp 000", {trigger_req, primed, holdoff_active});
      end
   endtask

   task automatic test_saturation();
      cfg(5, 20, 0, 0);
      restart();
      for (int i = 0; i < 10; i++) step(1, 1, 1, (i % 2) ? 255 : 0);
      cfg(250, 20, 1, 0);
      step(1, 0, 0, 0);
      step(1, 1, 0, 0);
      for (int i = 0; i < 10; i++) step(1, 1, 1, (i % 2) ? 255 : 0);
      tests++;
      if (ntrig !== 0 || nprimed !== 0) begin
         fails++;
         $display("FAIL saturation trig=%0d primed=%0d exp 0/0", ntrig, nprimed);
      end
   endtask

   task automatic test_random();
      bit r, a, e;
      int d;
      cfg(128, 8, 0, 1);
      restart();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 49) == 0)
            cfg($urandom_range(0, 255), $urandom_range(0, 40),
                1'($urandom_range(0, 1)), $urandom_range(0, 4));
         r = ($urandom_range(0, 299) != 0);
         a = ($urandom_range(0, 39) != 0);
         e = ($urandom_range(0, 3) != 0);
         d = ($urandom_range(0, 3) == 0) ? int'(level) + $urandom_range(0, 4) - 2
                                          : $urandom_range(0, 255);
         if (d < 0) d = 0;
         if (d > 255) d = 255;
         step(r, a, e, d);
      end
   endtask

   initial begin
      test_reset();
      test_rising();
      test_hyst_reject();
      test_falling();
      test_holdoff();
      test_disarm();
      test_saturation();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
